// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the instruction memory port, arbitrating between
// the boot loader (program write) and the fetch path, and registers the
// instruction/PC pair handed to decode.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   boot_req          loader asks for the memory (honoured in HALT only)
//   ld_valid/ld_ready loader write handshake; ld_addr/ld_data write word
//   ld_done           one-cycle pulse, loader finished
//   mem_addr/mem_we/mem_wdata  memory address, write enable, write data
//   mem_rdata         combinational read data for mem_addr
//   stall             decode back-pressure
//   br_taken/br_target redirect request and destination
//   if_instr/if_pc/if_valid    registered fetch bundle for decode
//   halted, busy_boot state flags (HALT, BOOT)
//
// Optional build macro FETCH_PERF_CNT_EN adds the saturating 16-bit
// counters perf_fetch and perf_stall.

module instr_fetch_ctrl #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               boot_req,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [PC_W-1:0]    ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_done,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    output logic               halted,
    output logic               busy_boot
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic            is_halt_op;

    // A word is captured only when neither flushed by a redirect nor
    // held by decode back-pressure.
    assign fetch_en   = (state == ST_RUN) && !br_taken && !stall;
    assign is_halt_op = (mem_rdata[INSTR_W-1 -: 4] == HALT_OP);

    // The loader writes in the same cycle it presents a word. Reset
    // gates the write so a word in flight during reset is dropped.
    always_comb begin
        ld_ready  = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state == ST_BOOT) begin
            ld_ready  = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            mem_we    = ld_valid && !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            if_instr  <= '0;
            if_pc     <= '0;
            if_valid  <= 1'b0;
            halted    <= 1'b0;
            busy_boot <= 1'b1;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if_valid <= 1'b0;
                    if (ld_done) begin
                        state     <= ST_RUN;
                        pc        <= RESET_PC;
                        busy_boot <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (br_taken) begin
                        pc       <= br_target;
                        if_valid <= 1'b0;
                    end else if (fetch_en) begin
                        if_instr <= mem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        // The halt word is delivered; pc stays on it.
                        if (is_halt_op) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (boot_req) begin
                        state     <= ST_BOOT;
                        halted    <= 1'b0;
                        busy_boot <= 1'b1;
                        if_valid  <= 1'b0;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_BOOT;
                    halted    <= 1'b0;
                    busy_boot <= 1'b1;
                    if_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic boot_entry;
    assign boot_entry = (state == ST_HALT) && boot_req;

    always_ff @(posedge clk) begin
        if (reset || boot_entry) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (fetch_en && perf_fetch != 16'hFFFF)
                perf_fetch <= perf_fetch + 16'd1;
            if (state == ST_RUN && stall &&
                perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural fetch model kept in the bench.

module tb_instr_fetch_ctrl;

    localparam int MB = 0;
    localparam int MR = 1;
    localparam int MH = 2;

    logic        clk = 1'b0;
    logic        reset, boot_req, ld_valid, ld_done;
    logic        stall, br_taken;
    logic [7:0]  ld_addr, br_target, mem_addr, if_pc;
    logic [15:0] ld_data, mem_wdata, mem_rdata, if_instr;
    logic        ld_ready, mem_we, if_valid, halted, busy_boot;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch, perf_stall;
`endif

    logic [15:0] env_mem [256];
    logic [15:0] ref_mem [256];
    logic        fill;

    int n_cmp = 0;
    int n_bad = 0;
    int m_mode, m_pc, m_ipc, m_instr, m_valid, m_pf, m_ps;

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk(clk), .reset(reset), .boot_req(boot_req),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .halted(halted), .busy_boot(busy_boot)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
    );

    // Instruction memory seen by the DUT.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = env_mem[mem_addr];

    // Behavioural model: one call per rising edge, using current inputs.
    task automatic model_edge();
        logic [15:0] w;
        if (reset) begin
            m_mode = MB; m_pc = 0; m_ipc = 0; m_instr = 0;
            m_valid = 0; m_pf = 0; m_ps = 0;
        end else if (m_mode == MB) begin
            if (ld_valid) ref_mem[ld_addr] = ld_data;
            m_valid = 0;
            if (ld_done) begin m_mode = MR; m_pc = 0; end
        end else if (m_mode == MR) begin
            if (stall && m_ps < 65535) m_ps++;
            if (br_taken) begin
                m_pc = br_target; m_valid = 0;
            end else if (!stall) begin
                w = ref_mem[m_pc];
                m_instr = w; m_ipc = m_pc; m_valid = 1;
                if (m_pf < 65535) m_pf++;
                if (w[15:12] == 4'hF) m_mode = MH;
                else m_pc = (m_pc + 1) % 256;
            end
        end else begin
            if (boot_req) begin
                m_mode = MB; m_valid = 0; m_pf = 0; m_ps = 0;
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    endtask

    function automatic logic [26:0] obs_vec();
        return {if_valid, if_pc, if_instr, halted, busy_boot};
    endfunction

    function automatic logic [26:0] exp_vec();
        logic h, b;
        h = (m_mode == MH);
        b = (m_mode == MB);
        return {m_valid[0], m_ipc[7:0], m_instr[15:0], h, b};
    endfunction

    function automatic logic [7:0] exp_addr();
        return (m_mode == MB) ? ld_addr : m_pc[7:0];
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        boot_req = 0; ld_valid = 0; ld_done = 0;
        stall = 0; br_taken = 0; ld_addr = 0; ld_data = 0;
        br_target = 0;
    endtask

    task automatic load_words(input logic [15:0] w[$]);
        if (m_mode == MH) begin
            boot_req = 1; tick(); boot_req = 0;
        end
        for (int i = 0; i < w.size(); i++) begin
            ld_valid = 1; ld_addr = 8'(i); ld_data = w[i];
            tick();
        end
        ld_valid = 0; ld_done = 1; tick(); ld_done = 0;
    endtask

    task automatic test_reset();
        reset = 1; ld_valid = 1; ld_addr = 8'h33; ld_data = 16'hABCD;
        tick();
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_we got %b want 0", mem_we);
        end
        tick();
        reset = 0; ld_valid = 0;
        #1;
        n_cmp++;
        if (obs_vec() !== 27'h1) begin
            n_bad++;
            $display("FAIL rst_vals got %h want %h", obs_vec(), 27'h1);
        end
        n_cmp++;
        if (ld_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ld got rdy=%b we=%b want 1/0",
                     ld_ready, mem_we);
        end
    endtask

    task automatic test_boot_load();
        logic [15:0] prog [3];
        int we_cnt;
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'hF000;
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_addr = 8'(i); ld_data = prog[i];
            ld_done = (i == 2);
            #1;
            we_cnt += int'(mem_we);
            n_cmp++;
            if (mem_addr !== 8'(i) || mem_wdata !== prog[i]) begin
                n_bad++;
                $display("FAIL boot_wr%0d got %h/%h want %h/%h", i,
                         mem_addr, mem_wdata, 8'(i), prog[i]);
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (we_cnt != 3 || busy_boot !== 1'b0 || if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_run got we=%0d bb=%b v=%b want 3/0/0",
                     we_cnt, busy_boot, if_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 8'(k) ||
                if_instr !== prog[k]) begin
                n_bad++;
                $display("FAIL boot_seq%0d got %b/%h/%h want 1/%h/%h", k,
                         if_valid, if_pc, if_instr, 8'(k), prog[k]);
            end
        end
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++;
            $display("FAIL boot_halt got %b want 1", halted);
        end
        stall = 1; tick(); stall = 0;
        n_cmp++;
        if (if_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_hold got %b want 1", if_valid);
        end
        tick(); tick();
        n_cmp++;
        if (if_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL halt_drop got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        logic [15:0] w[$];
        w = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'hF000};
        load_words(w);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_instr !== 16'h1001 || if_pc !== 8'h00 ||
                if_valid !== 1'b1 || mem_addr !== 8'h01) begin
                n_bad++;
                $display("FAIL stall_hold%0d got %h/%h/%h want 1001/00/01",
                         i, if_instr, if_pc, mem_addr);
            end
        end
        stall = 0;
        for (int k = 1; k < 3; k++) begin
            tick();
            n_cmp++;
            if (if_pc !== 8'(k) || if_instr !== w[k] ||
                if_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_resume%0d got %h/%h want %h/%h", k,
                         if_pc, if_instr, 8'(k), w[k]);
            end
        end
    endtask

    task automatic test_branch_stall();
        br_taken = 1; br_target = 8'h40; stall = 1;
        tick();
        br_taken = 0; stall = 0;
        n_cmp++;
        if (if_valid !== 1'b0 || mem_addr !== 8'h40) begin
            n_bad++;
            $display("FAIL br_flush got v=%b a=%h want 0/40",
                     if_valid, mem_addr);
        end
        tick();
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 8'h40 ||
            if_instr !== ref_mem[8'h40]) begin
            n_bad++;
            $display("FAIL br_target got %b/%h/%h want 1/40/%h",
                     if_valid, if_pc, if_instr, ref_mem[8'h40]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [3];
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01;
        br_taken = 1; br_target = 8'hFF;
        tick();
        br_taken = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_pc !== seq[i] || if_instr !== ref_mem[seq[i]]) begin
                n_bad++;
                $display("FAIL wrap%0d got %h/%h want %h/%h", i,
                         if_pc, if_instr, seq[i], ref_mem[seq[i]]);
            end
        end
    endtask

    task automatic test_reboot();
        boot_req = 1; tick(); boot_req = 0;
        n_cmp++;
        if (busy_boot !== 1'b0 || ld_ready !== 1'b0 ||
            obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reboot_run got bb=%b rdy=%b want 0/0",
                     busy_boot, ld_ready);
        end
        ld_valid = 1; ld_addr = 8'h05; ld_data = 16'hF5F5; stall = 1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL run_ld_drop got %b want 0", mem_we);
        end
        tick();
        ld_valid = 0; stall = 0;
        br_taken = 1; br_target = 8'h04; tick(); br_taken = 0;
        tick();
        n_cmp++;
        if (halted !== 1'b1 || if_instr !== 16'hF000) begin
            n_bad++;
            $display("FAIL reboot_halt got %b/%h want 1/F000",
                     halted, if_instr);
        end
        br_taken = 1; br_target = 8'h10; tick(); br_taken = 0;
        n_cmp++;
        if (halted !== 1'b1 || mem_addr !== 8'h04) begin
            n_bad++;
            $display("FAIL halt_br got %b/%h want 1/04", halted, mem_addr);
        end
        boot_req = 1; tick(); boot_req = 0;
        n_cmp++;
        if (busy_boot !== 1'b1 || ld_ready !== 1'b1 ||
            if_valid !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reboot got bb=%b rdy=%b v=%b h=%b want 1/1/0/0",
                     busy_boot, ld_ready, if_valid, halted);
        end
    endtask

    task automatic test_reset_mid_load();
        ld_valid = 1; ld_addr = 8'h08; ld_data = 16'h5A5A;
        tick();
        reset = 1; ld_addr = 8'h09; ld_data = 16'h6B6B;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rml_we got %b want 0", mem_we);
        end
        tick();
        reset = 0; ld_valid = 0;
        n_cmp++;
        if (obs_vec() !== 27'h1) begin
            n_bad++;
            $display("FAIL rml_vals got %h want %h", obs_vec(), 27'h1);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (perf_fetch !== 16'h0 || perf_stall !== 16'h0) begin
            n_bad++;
            $display("FAIL rml_perf got %h/%h want 0/0",
                     perf_fetch, perf_stall);
        end
`endif
        ld_done = 1; tick(); ld_done = 0;
        tick();
        n_cmp++;
        if (if_pc !== 8'h00 || if_instr !== 16'h1001) begin
            n_bad++;
            $display("FAIL rml_pc got %h/%h want 00/1001", if_pc, if_instr);
        end
        br_taken = 1; br_target = 8'h08; tick(); br_taken = 0;
        tick();
        n_cmp++;
        if (if_instr !== 16'h5A5A) begin
            n_bad++;
            $display("FAIL rml_wr got %h want 5A5A", if_instr);
        end
        tick();
        n_cmp++;
        if (if_pc !== 8'h09 || if_instr !== ref_mem[9] ||
            if_instr === 16'h6B6B) begin
            n_bad++;
            $display("FAIL rml_drop got %h want %h", if_instr, ref_mem[9]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            idle_inputs();
            reset = ($urandom_range(0, 199) == 0);
            if (m_mode == MB) begin
                ld_valid = $urandom_range(0, 1) == 1;
                ld_addr = 8'($urandom);
                ld_data = 16'($urandom);
                if ($urandom_range(0, 7) != 0) ld_data[15:12] = 4'h1;
                ld_done = ($urandom_range(0, 29) == 0);
            end else begin
                stall = ($urandom_range(0, 9) < 4);
                br_taken = ($urandom_range(0, 9) == 0);
                br_target = 8'($urandom);
                boot_req = ($urandom_range(0, 9) == 0);
                ld_valid = $urandom_range(0, 1) == 1;
            end
            #1;
            n_cmp++;
            if (mem_we !== (m_mode == MB && ld_valid && !reset) ||
                mem_addr !== exp_addr() ||
                ld_ready !== (m_mode == MB)) begin
                n_bad++;
                $display("FAIL rnd_mem c=%0d got we=%b a=%h r=%b want a=%h",
                         c, mem_we, mem_addr, ld_ready, exp_addr());
            end
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rnd_out c=%0d got %h want %h",
                         c, obs_vec(), exp_vec());
            end
`ifdef FETCH_PERF_CNT_EN
            n_cmp++;
            if (perf_fetch !== 16'(m_pf) || perf_stall !== 16'(m_ps)) begin
                n_bad++;
                $display("FAIL rnd_perf c=%0d got %h/%h want %h/%h", c,
                         perf_fetch, perf_stall, 16'(m_pf), 16'(m_ps));
            end
`endif
        end
    endtask

    initial begin
        reset = 1; fill = 0;
        idle_inputs();
        m_mode = MB; m_pc = 0; m_ipc = 0; m_instr = 0;
        m_valid = 0; m_pf = 0; m_ps = 0;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = 16'($urandom_range(0, 16'hEFFF));
        fill = 1;
        @(posedge clk);
        #1;
        fill = 0;
        test_reset();
        test_boot_load();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_reboot();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the 256x16 instruction ROM/RAM.
- Owns the read-address (PC) mux and arbitrates memory ownership between a boot loader (program write) and the fetch path.
- Produces a registered instruction/PC pair for decode, with stall, branch redirect and halt handling.
- Sits between the loader/debug port, the instruction memory and the decode stage.

Parameters:
PC_W, 8, program counter and memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, first fetch address after boot completes
HALT_OP, 4'hF, opcode (instr[INSTR_W-1:INSTR_W-4]) that halts fetch

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
boot_req  in  1  loader requests memory ownership (honoured only in HALT)
ld_valid  in  1  loader write word valid
ld_ready  out  1  controller accepts loader word
ld_addr  in  PC_W  loader write address
ld_data  in  INSTR_W  loader write data
ld_done  in  1  loader finished, one-cycle pulse
mem_addr  out  PC_W  memory address (read or write)
mem_we  out  1  memory write enable
mem_wdata  out  INSTR_W  memory write data
mem_rdata  in  INSTR_W  memory read data, combinational from mem_addr
stall  in  1  decode back-pressure
br_taken  in  1  redirect request
br_target  in  PC_W  redirect address
if_instr  out  INSTR_W  fetched instruction (registered)
if_pc  out  PC_W  address of if_instr (registered)
if_valid  out  1  if_instr/if_pc valid
halted  out  1  high in HALT state
busy_boot  out  1  high in BOOT state

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high, sampled only on the rising edge.
- Reset values: state=BOOT, pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, busy_boot=1, mem_we=0.
- States: BOOT, RUN, HALT (2-bit encoded).
- BOOT:
  - ld_ready=1.
  - mem_addr=ld_addr, mem_wdata=ld_data, mem_we=ld_valid (combinational, write same cycle).
  - if_valid held 0.
  - ld_done -> RUN, pc<=RESET_PC. A write coincident with ld_done is still performed.
- RUN:
  - ld_ready=0, mem_we=0, mem_addr=pc.
  - Each non-stalled cycle: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1. Fetch latency is 1 cycle.
  - PC wraps modulo 2^PC_W (8'hFF -> 8'h00).
  - stall=1: pc, if_instr, if_pc, if_valid all hold.
  - br_taken=1 (priority over stall): pc<=br_target, if_valid<=0 next cycle (flush); first redirected instruction appears 2 cycles after br_taken.
  - Halt: when a captured word has opcode==HALT_OP (captured = not stalled and not flushed), it is delivered with if_valid=1. State -> HALT the same edge; pc not incremented.
  - boot_req ignored in RUN.
- HALT:
  - halted=1, pc frozen.
  - if_valid holds until stall=0 for one cycle, then clears and stays 0.
  - br_taken ignored.
  - boot_req=1 -> BOOT next cycle, if_valid<=0.
- Reset mid-operation (any state, including mid-load): returns to BOOT reset values next edge. Writes in progress are not completed.
- ld_ready is 0 in RUN and HALT; loader writes there are dropped.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch (16 bit) and perf_stall (16 bit), both saturating at 16'hFFFF and cleared on reset and on BOOT entry.
  - perf_fetch increments on each cycle if_valid is loaded with 1.
  - perf_stall increments on each RUN cycle with stall=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Boot load: reset; write 3'h0..3'h2 = 16'h1001,16'h2002,16'hF000 via ld_valid, pulse ld_done -> mem_we pulses 3 times, RUN entered. if_instr sequence 1001,2002,F000 at pc 0,1,2, one per cycle. halted=1 after F000; if_valid drops after one non-stalled cycle.
- Stall: during RUN, hold stall=1 for 3 cycles at pc=1 -> if_instr/if_pc frozen at 16'h1001/0. Fetch resumes with pc=1 word after release, no duplicates or skips.
- Branch + stall: br_taken=1, br_target=8'h40, stall=1 same cycle -> if_valid=0 next cycle, if_pc=8'h40 two cycles later.
- Wrap: br_target=8'hFF with non-halt words -> if_pc sequence FF,00,01.
- Re-boot: in HALT assert boot_req -> busy_boot=1 next cycle, ld_ready=1. Same boot_req in RUN -> no effect.
- Reset mid-load after 1 write -> state BOOT, if_valid=0, pc=RESET_PC. With FETCH_PERF_CNT_EN, counters read 0.
